load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 167 ++++++++++++++++
 tb/tb_load_store_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns M-stage loads/stores into single-beat data-bus accesses with a timeout.
// Optional: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses without touching the bus.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        FaultM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  // state  | meaning
  // IDLE   | waiting for an M-stage load/store
  // ACCESS | bus_req held until bus_ack or timeout
  // DONE   | result/fault presented, pipeline released for one cycle
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t         state;
  size_t          size_c, size_q;
  logic           sgn_c, sgn_q;
  logic [1:0]     lane_q;
  logic           store_q;
  logic [CW-1:0]  cnt;
  logic [3:0]     be_c;
  logic [31:0]    wdata_c;
  logic           misalign_c;
  logic [7:0]     lane_b;
  logic [15:0]    lane_h;
  logic [31:0]    ld_fmt;
  logic           req;

  assign req = MemReadM | MemWriteM;

  always_comb begin
    size_c = SZ_W;
    sgn_c  = 1'b0;
    case (Funct3M)
      3'b000: begin size_c = SZ_B; sgn_c = 1'b1; end
      3'b001: begin size_c = SZ_H; sgn_c = 1'b1; end
      3'b100: size_c = SZ_B;
      3'b101: size_c = SZ_H;
      default: size_c = SZ_W;
    endcase
  end

  // Half accesses only use addr[1]; word accesses ignore both low bits.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = WriteDataM;
    case (size_c)
      SZ_B: begin
        be_c    = 4'b0001 << ALUResultM[1:0];
        wdata_c = {4{WriteDataM[7:0]}};
      end
      SZ_H: begin
        be_c    = 4'b0011 << {ALUResultM[1], 1'b0};
        wdata_c = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = WriteDataM;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_c = ((size_c == SZ_H) && ALUResultM[0]) ||
                      ((size_c == SZ_W) && (ALUResultM[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  always_comb begin
    lane_b = bus_rdata[{lane_q, 3'b000} +: 8];
    lane_h = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      SZ_B:    ld_fmt = {{24{sgn_q & lane_b[7]}}, lane_b};
      SZ_H:    ld_fmt = {{16{sgn_q & lane_h[15]}}, lane_h};
      default: ld_fmt = bus_rdata;
    endcase
  end

  // Stall is combinational so the request cycle itself already freezes the pipe.
  assign StallM = ~rst & (((state == IDLE) & req) | (state == ACCESS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      size_q    <= SZ_W;
      sgn_q     <= 1'b0;
      lane_q    <= 2'b00;
      store_q   <= 1'b0;
      ReadDataM <= '0;
      FaultM    <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            size_q  <= size_c;
            sgn_q   <= sgn_c;
            lane_q  <= ALUResultM[1:0];
            store_q <= MemWriteM;
            if (misalign_c) begin
              state     <= DONE;
              FaultM    <= 1'b1;
              ReadDataM <= '0;
            end else begin
              state     <= ACCESS;
              cnt       <= '0;
              bus_req   <= 1'b1;
              bus_we    <= MemWriteM;
              bus_addr  <= {ALUResultM[31:2], 2'b00};
              bus_be    <= be_c;
              bus_wdata <= wdata_c;
            end
          end
        end
        ACCESS: begin
          if (bus_ack || (cnt == CW'(TIMEOUT - 1))) begin
            state     <= DONE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            if (!bus_ack) begin
              FaultM    <= 1'b1;
              ReadDataM <= '0;
            end else if (!store_q) begin
              ReadDataM <= ld_fmt;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          FaultM <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level memory model, randomized bus latency and stray acks.
module tb_load_store_unit;
  localparam int TO = 6;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemReadM = 1'b0, MemWriteM = 1'b0;
  logic [2:0]  Funct3M = 3'b000;
  logic [31:0] ALUResultM = '0, WriteDataM = '0;
  logic [31:0] ReadDataM;
  logic        StallM, FaultM;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .FaultM(FaultM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          stall;
    int          reqs;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  int          errs = 0, checks = 0;
  logic [7:0]  ref_mem [int unsigned];
  logic [31:0] bus_mem [int unsigned];
  logic [31:0] rd_hold = '0;
  int          ack_delay = 0;
  bit          stray_en = 1'b0;
  bit          late_ack = 1'b0;

  function automatic logic [31:0] init_word(input logic [31:0] widx);
    return widx * 32'h9E37_79B1 + 32'h1357_9BDF;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    if (ref_mem.exists(a)) return ref_mem[a];
    w = init_word(a >> 2);
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic logic [31:0] slave_word(input logic [31:0] widx);
    if (bus_mem.exists(widx)) return bus_mem[widx];
    return init_word(widx);
  endfunction

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    bus_mem[addr >> 2] = val;
    for (int i = 0; i < 4; i++) ref_mem[{addr[31:2], 2'b00} + i] = val[8*i +: 8];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accesses described as n bytes starting at an aligned base address.
  task automatic build_exp(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int delay, output exp_t e);
    int n;
    bit sgn, trap, acked;
    logic [31:0] base;
    longint v;
    n     = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
    sgn   = (f3 == 3'b000 || f3 == 3'b001);
    base  = addr & ~(32'(n - 1));
    trap  = TRAP && (base != addr);
    acked = (delay >= 0) && (delay < TO);
    e.we    = wr;
    e.addr  = {addr[31:2], 2'b00};
    e.be    = 4'b0000;
    for (int i = 0; i < n; i++) e.be[int'(base[1:0]) + i] = 1'b1;
    for (int j = 0; j < 4; j++) e.wdata[8*j +: 8] = wd[8*(j % n) +: 8];
    e.fault = 1'b0;
    e.rdata = rd_hold;
    if (trap) begin
      e.reqs = 0; e.stall = 1; e.fault = 1'b1; e.rdata = '0;
    end else if (!acked) begin
      e.reqs = TO; e.stall = TO + 1; e.fault = 1'b1; e.rdata = '0;
    end else begin
      e.reqs  = delay + 1;
      e.stall = delay + 2;
      if (wr) begin
        for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v | (longint'(ref_byte(base + i)) << (8 * i));
        if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        e.rdata = v[31:0];
      end
    end
    rd_hold = e.rdata;
  endtask

  // Bus slave: acks after ack_delay ACCESS cycles; stray acks while idle.
  initial begin
    bit in_acc;
    int wcnt;
    logic [31:0] w;
    in_acc = 1'b0;
    wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_req) begin
        if (!in_acc) begin in_acc = 1'b1; wcnt = 0; end
        else wcnt++;
        if (ack_delay >= 0 && wcnt == ack_delay) begin
          w = slave_word(bus_addr >> 2);
          bus_ack = 1'b1;
          bus_rdata = w;
          if (bus_we) begin
            for (int i = 0; i < 4; i++) if (bus_be[i]) w[8*i +: 8] = bus_wdata[8*i +: 8];
            bus_mem[bus_addr >> 2] = w;
          end
        end else begin
          bus_ack = 1'b0;
          bus_rdata = $urandom;
        end
      end else begin
        in_acc = 1'b0;
        bus_ack = late_ack | (stray_en && ($urandom_range(0, 3) == 0));
        bus_rdata = $urandom;
      end
    end
  end

  // Monitor: pops the scoreboard on the DONE cycle (request still shown, stall released).
  initial begin
    bit prev_rst;
    bit done;
    int stall_n, req_n;
    exp_t e;
    prev_rst = 1'b0;
    stall_n = 0;
    req_n = 0;
    forever begin
      @(negedge clk);
      if (prev_rst) begin
        chk("rst_ReadDataM", ReadDataM, 32'h0);
        chk("rst_StallM", {31'b0, StallM}, 32'h0);
        chk("rst_FaultM", {31'b0, FaultM}, 32'h0);
        chk("rst_bus_req", {31'b0, bus_req}, 32'h0);
        chk("rst_bus_we", {31'b0, bus_we}, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_be", {28'b0, bus_be}, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
      end
      prev_rst = rst;
      if (rst) begin
        exp_q.delete();
        stall_n = 0;
        req_n = 0;
      end else if (exp_q.size() == 0) begin
        chk("idle_bus_req", {31'b0, bus_req}, 32'h0);
        chk("idle_StallM", {31'b0, StallM}, 32'h0);
        chk("idle_FaultM", {31'b0, FaultM}, 32'h0);
        chk("idle_ReadDataM", ReadDataM, rd_hold);
      end else begin
        e = exp_q[0];
        done = !StallM && (MemReadM || MemWriteM);
        if (e.reqs == 0) begin
          chk("trap_bus_req", {31'b0, bus_req}, 32'h0);
        end else if (bus_req) begin
          req_n++;
          chk("bus_we", {31'b0, bus_we}, {31'b0, e.we});
          chk("bus_addr", bus_addr, e.addr);
          chk("bus_be", {28'b0, bus_be}, {28'b0, e.be});
          if (e.we) chk("bus_wdata", bus_wdata, e.wdata);
        end
        if (StallM) stall_n++;
        if (done) begin
          chk("ReadDataM", ReadDataM, e.rdata);
          chk("FaultM", {31'b0, FaultM}, {31'b0, e.fault});
          chk("stall_cycles", stall_n, e.stall);
          chk("bus_req_cycles", req_n, e.reqs);
          void'(exp_q.pop_front());
          stall_n = 0;
          req_n = 0;
        end else begin
          chk("fault_outside_done", {31'b0, FaultM}, 32'h0);
        end
      end
    end
  end

  task automatic run(input bit rd, input bit wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd, input int delay);
    exp_t e;
    bit ok;
    build_exp(wr, f3, addr, wd, delay, e);
    ack_delay = delay;
    exp_q.push_back(e);
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
    ok = 1'b0;
    for (int k = 0; k < TO + 8; k++) begin
      @(negedge clk);
      if (!StallM) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      $display("FAIL completion_wait: StallM still 1 after %0d cycles, required 0", TO + 8);
      $fatal(1, "stall never released");
    end
    @(posedge clk);
    #1;
    MemReadM = 1'b0; MemWriteM = 1'b0;
    Funct3M = 3'($urandom); ALUResultM = $urandom; WriteDataM = $urandom;
  endtask

  initial begin
    exp_t e;
    bit rd, wr;
    int r, dly;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    preload(32'h1000, 32'h80FF_FF12);
    run(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 0);          // LB sign-extended from lane 3
    run(1'b0, 1'b1, 3'b001, 32'h2002, 32'h1234_ABCD, 0);  // SH upper half, replicated data
    run(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0, 5);          // LW, late ack
    run(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0, -1);         // LW timeout
    run(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0, TO - 1);     // ack on the last allowed cycle
    run(1'b1, 1'b0, 3'b010, 32'h3001, 32'h0, 0);          // misaligned LW
    run(1'b1, 1'b1, 3'b000, 32'h2001, 32'h0000_0055, 0);  // both strobes: store
    run(1'b1, 1'b0, 3'b100, 32'h2001, 32'h0, 1);          // LBU
    run(1'b1, 1'b0, 3'b101, 32'h2002, 32'h0, 0);          // LHU
    run(1'b1, 1'b0, 3'b001, 32'h2002, 32'h0, 2);          // LH
    run(1'b0, 1'b1, 3'b101, 32'h2003, 32'hCAFE_BEEF, 0);  // SH misaligned by one byte
    run(1'b1, 1'b0, 3'b110, 32'h2000, 32'h0, 0);          // reserved code behaves as LW

    // Reset during the second ACCESS cycle, then a late ack.
    build_exp(1'b0, 3'b010, 32'h5000, 32'h0, -1, e);
    exp_q.push_back(e);
    ack_delay = -1;
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h5000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; MemReadM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; late_ack = 1'b1; rd_hold = '0;
    repeat (2) begin @(posedge clk); #1; end
    late_ack = 1'b0;
    run(1'b0, 1'b1, 3'b010, 32'h2000, 32'h0BAD_F00D, 1);  // store keeps ReadDataM at 0

    stray_en = 1'b1;
    for (int t = 0; t < 200; t++) begin
      rd = 1'($urandom_range(0, 1));
      wr = rd ? ($urandom_range(0, 3) == 0) : 1'b1;
      r = $urandom_range(0, 9);
      dly = (r < 6) ? (r % 3) : (r == 6) ? TO - 1 : (r == 7) ? TO : (r == 8) ? -1
            : int'($urandom_range(0, TO - 1));
      run(rd, wr, 3'($urandom_range(0, 7)), 32'h4000 + $urandom_range(0, 31), $urandom, dly);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    stray_en = 1'b0;
    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
